// File: rtl/fighter_fsm_if.sv
// fighter_fsm_if: groups the per-frame controls and the fighter's visible state.
// Ports: frame_tick, btn_left, btn_right, btn_attack, hit_in toward the fighter;
//        x_pos, state, atk_dir, phase_cnt, hitbox_active back from it.
interface fighter_fsm_if;
  logic       frame_tick;
  logic       btn_left;
  logic       btn_right;
  logic       btn_attack;
  logic       hit_in;
  logic [9:0] x_pos;
  logic [2:0] state;
  logic       atk_dir;
  logic [4:0] phase_cnt;
  logic       hitbox_active;

  // Controller side: drives the inputs, observes the fighter.
  modport master (
    output frame_tick, btn_left, btn_right, btn_attack, hit_in,
    input  x_pos, state, atk_dir, phase_cnt, hitbox_active
  );

  // Fighter side.
  modport slave (
    input  frame_tick, btn_left, btn_right, btn_attack, hit_in,
    output x_pos, state, atk_dir, phase_cnt, hitbox_active
  );
endinterface

// File: rtl/fighter_fsm.sv
// fighter_fsm: per-frame movement / attack / hitstun state machine for one fighter.
// Latency: state, x_pos, phase_cnt, atk_dir update on the clk edge where frame_tick=1;
//          hitbox_active follows state combinationally. No backpressure: frame_tick is a strobe.
// Ports: clk, reset (async, active-high), bus (fighter_fsm_if.slave).
// Build option: define FIGHTER_HITSTUN_EN to enable hit_in / STUN / knockback.
module fighter_fsm #(
  parameter int SCREEN_W       = 640,
  parameter int SPRITE_W       = 64,
  parameter int START_X        = 10,
  parameter int FACING_LEFT    = 0,
  parameter int FWD_STEP       = 3,
  parameter int BWD_STEP       = 2,
  parameter int NEU_SU         = 5,
  parameter int NEU_ACT        = 2,
  parameter int NEU_REC        = 16,
  parameter int DIR_SU         = 4,
  parameter int DIR_ACT        = 3,
  parameter int DIR_REC        = 15,
  parameter int HITSTUN_FRAMES = 12,
  parameter int KNOCKBACK      = 8
) (
  input logic         clk,
  input logic         reset,
  fighter_fsm_if.slave bus
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_FWD  = 3'd1;
  localparam logic [2:0] S_BWD  = 3'd2;
  localparam logic [2:0] S_SU   = 3'd3;
  localparam logic [2:0] S_ACT  = 3'd4;
  localparam logic [2:0] S_REC  = 3'd5;
  localparam logic [2:0] S_STUN = 3'd6;

  // 11-bit so that x+step and x-step never wrap before clamping.
  localparam logic [10:0] X_MAX  = 11'(SCREEN_W - SPRITE_W);
  localparam logic [10:0] FWD_D  = 11'(FWD_STEP);
  localparam logic [10:0] BWD_D  = 11'(BWD_STEP);
  // Forward means increasing x unless the fighter faces left.
  localparam logic        FWD_UP = (FACING_LEFT == 0);

  if (NEU_SU < 1 || NEU_SU > 31 || NEU_ACT < 1 || NEU_ACT > 31 ||
      NEU_REC < 1 || NEU_REC > 31 || DIR_SU < 1 || DIR_SU > 31 ||
      DIR_ACT < 1 || DIR_ACT > 31 || DIR_REC < 1 || DIR_REC > 31 ||
      HITSTUN_FRAMES < 1 || HITSTUN_FRAMES > 31 || KNOCKBACK < 0) begin : g_bad_param
    $error("fighter_fsm: phase length outside 1..31 or negative knockback");
  end

  logic [2:0] state_q, state_d;
  logic [9:0] x_q, x_d;
  logic [4:0] cnt_q, cnt_d;
  logic       dir_q, dir_d;
  logic [4:0] phase_len;
  logic       phase_done;
  logic       fwd_btn, bwd_btn;

  // Move x by d toward increasing (up=1) or decreasing x, clamped to [0, X_MAX].
  function automatic logic [9:0] shift_x(input logic [9:0] x, input logic [10:0] d,
                                         input logic up);
    logic [10:0] wide;
    if (up) begin
      wide = {1'b0, x} + d;
      if (wide > X_MAX) wide = X_MAX;
    end else if ({1'b0, x} < d) begin
      wide = '0;
    end else begin
      wide = {1'b0, x} - d;
    end
    return 10'(wide);
  endfunction

  // Both directions held cancel out.
  always_comb begin
    if (FACING_LEFT != 0) begin
      fwd_btn = bus.btn_left & ~bus.btn_right;
      bwd_btn = bus.btn_right & ~bus.btn_left;
    end else begin
      fwd_btn = bus.btn_right & ~bus.btn_left;
      bwd_btn = bus.btn_left & ~bus.btn_right;
    end
  end

  // Length of the timed phase we are in; atk_dir picks the neutral or directional set.
  always_comb begin
    phase_len = 5'd1;
    case (state_q)
      S_SU:  phase_len = dir_q ? 5'(DIR_SU)  : 5'(NEU_SU);
      S_ACT: phase_len = dir_q ? 5'(DIR_ACT) : 5'(NEU_ACT);
      S_REC: phase_len = dir_q ? 5'(DIR_REC) : 5'(NEU_REC);
`ifdef FIGHTER_HITSTUN_EN
      S_STUN: phase_len = 5'(HITSTUN_FRAMES);
`endif
      default: phase_len = 5'd1;
    endcase
  end

  assign phase_done = (cnt_q == phase_len - 5'd1);

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    cnt_d   = cnt_q;
    dir_d   = dir_q;
`ifdef FIGHTER_HITSTUN_EN
    // A hit overrides everything, including an ongoing stun (restarts it).
    if (bus.hit_in) begin
      state_d = S_STUN;
      cnt_d   = 5'd0;
      dir_d   = 1'b0;
      x_d     = shift_x(x_q, 11'(KNOCKBACK), !FWD_UP);
    end else
`endif
    begin
      case (state_q)
        S_IDLE: begin
          if (bus.btn_attack) begin
            state_d = S_SU;
            cnt_d   = 5'd0;
            dir_d   = 1'b0;
          end else if (fwd_btn) begin
            state_d = S_FWD;
          end else if (bwd_btn) begin
            state_d = S_BWD;
          end
        end
        S_FWD, S_BWD: begin
          // Attack or release consume the tick without moving.
          if (bus.btn_attack) begin
            state_d = S_SU;
            cnt_d   = 5'd0;
            dir_d   = 1'b1;
          end else if ((state_q == S_FWD) ? !fwd_btn : !bwd_btn) begin
            state_d = S_IDLE;
          end else if (state_q == S_FWD) begin
            x_d = shift_x(x_q, FWD_D, FWD_UP);
          end else begin
            x_d = shift_x(x_q, BWD_D, !FWD_UP);
          end
        end
        S_SU, S_ACT, S_REC: begin
          if (phase_done) begin
            cnt_d = 5'd0;
            if (state_q == S_REC) begin
              state_d = S_IDLE;
              dir_d   = 1'b0;
            end else begin
              state_d = state_q + 3'd1;
            end
          end else begin
            cnt_d = cnt_q + 5'd1;
          end
        end
`ifdef FIGHTER_HITSTUN_EN
        S_STUN: begin
          if (phase_done) begin
            state_d = S_IDLE;
            cnt_d   = 5'd0;
          end else begin
            cnt_d = cnt_q + 5'd1;
          end
        end
`endif
        default: begin
          // Unreachable codes fall back to a clean IDLE.
          state_d = S_IDLE;
          cnt_d   = 5'd0;
          dir_d   = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      x_q     <= 10'(START_X);
      cnt_q   <= 5'd0;
      dir_q   <= 1'b0;
    end else if (bus.frame_tick) begin
      state_q <= state_d;
      x_q     <= x_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
    end
  end

  assign bus.x_pos         = x_q;
  assign bus.state         = state_q;
  assign bus.atk_dir       = dir_q;
  assign bus.phase_cnt     = cnt_q;
  assign bus.hitbox_active = (state_q == S_ACT);

endmodule
